// File: rtl/hour_cnt_bcd.sv
// Hour stage of the clock chain: binary 0..23 hour register,
// manual adjust, day carry and 12 h / 24 h BCD display decode.
module hour_cnt_bcd #(
   parameter int unsigned RESET_HOUR = 0,
   parameter bit          HAS_12H    = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CLR,
   input  logic       en1hz,
   input  logic       ENsec,
   input  logic       ENmin,
   input  logic       mode24,
   input  logic       adj_up,
   input  logic       adj_dn,
   output logic [1:0] QH,
   output logic [3:0] QL,
   output logic       pm,
   output logic       carry_day
);

   localparam logic [4:0] RST_H = 5'(RESET_HOUR);
   localparam logic [4:0] H_MAX = 5'd23;

   logic [4:0] h_q, h_d;
   logic       carry_q, carry_d;
   logic       tick;
   logic       use24;
   logic [4:0] h12;
   logic [4:0] d;

   assign tick  = en1hz & ENsec & ENmin;
   assign use24 = mode24 | ~HAS_12H;

   // Next hour: clear beats adjust, adjust swallows a coincident tick.
   always_comb begin
      h_d     = h_q;
      carry_d = 1'b0;
      if (CLR) begin
         h_d = RST_H;
      end else if (adj_up & adj_dn) begin
         h_d = h_q;
      end else if (adj_up) begin
         h_d = (h_q == H_MAX) ? 5'd0 : h_q + 5'd1;
      end else if (adj_dn) begin
         h_d = (h_q == 5'd0) ? H_MAX : h_q - 5'd1;
      end else if (tick) begin
         if (h_q == H_MAX) begin
            h_d     = 5'd0;
            carry_d = 1'b1;
         end else begin
            h_d = h_q + 5'd1;
         end
      end
   end

   // Hour register and day-carry pulse.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         h_q     <= RST_H;
         carry_q <= 1'b0;
      end else begin
         h_q     <= h_d;
         carry_q <= carry_d;
      end
   end

   // Display decode straight from the register, no added latency.
   always_comb begin
      h12 = (h_q >= 5'd12) ? h_q - 5'd12 : h_q;
      if (use24) begin
         d = h_q;
      end else begin
         d = (h12 == 5'd0) ? 5'd12 : h12;
      end
      if (d >= 5'd20) begin
         QH = 2'd2;
         QL = 4'(d - 5'd20);
      end else if (d >= 5'd10) begin
         QH = 2'd1;
         QL = 4'(d - 5'd10);
      end else begin
         QH = 2'd0;
         QL = d[3:0];
      end
      pm = ~use24 & (h_q >= 5'd12);
   end

   assign carry_day = carry_q;

endmodule

// File: tb/tb_hour_cnt_bcd.sv
// Scoreboard bench for hour_cnt_bcd: two instances (reset hour 0 and
// 12) share stimulus; expectations are queued with a due time.
module tb_hour_cnt_bcd;

   logic CLK = 1'b0;
   logic RST, CLR, en1hz, ENsec, ENmin, mode24, adj_up, adj_dn;
   logic [1:0] QH0, QH1;
   logic [3:0] QL0, QL1;
   logic pm0, pm1, cd0, cd1;

   typedef struct {
      longint due;
      int     h0;
      bit     c0;
      bit     c1;
      bit     m24;
      string  name;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   hour_cnt_bcd #(.RESET_HOUR(0), .HAS_12H(1'b1)) dut0 (
      .CLK(CLK), .RST(RST), .CLR(CLR), .en1hz(en1hz),
      .ENsec(ENsec), .ENmin(ENmin), .mode24(mode24),
      .adj_up(adj_up), .adj_dn(adj_dn),
      .QH(QH0), .QL(QL0), .pm(pm0), .carry_day(cd0)
   );

   hour_cnt_bcd #(.RESET_HOUR(12), .HAS_12H(1'b1)) dut1 (
      .CLK(CLK), .RST(RST), .CLR(CLR), .en1hz(en1hz),
      .ENsec(ENsec), .ENmin(ENmin), .mode24(mode24),
      .adj_up(adj_up), .adj_dn(adj_dn),
      .QH(QH1), .QL(QL1), .pm(pm1), .carry_day(cd1)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] disp(int h, bit m24, bit c);
      int dd;
      int qh;
      int ql;
      bit p;
      if (m24) begin
         dd = h;
         p  = 1'b0;
      end else begin
         dd = (h % 12 == 0) ? 12 : h % 12;
         p  = (h >= 12);
      end
      qh = dd / 10;
      ql = dd % 10;
      return {qh[1:0], ql[3:0], p, c};
   endfunction

   initial begin : monitor
      exp_t e;
      logic [7:0] got, want;
      forever begin
         #1;
         while (q.size() > 0 && q[0].due <= $time) begin
            e = q.pop_front();
            got  = {QH0, QL0, pm0, cd0};
            want = disp(e.h0, e.m24, e.c0);
            checks++;
            if (got !== want) begin
               failures++;
               $display("FAIL %s dut0 got=%h want=%h t=%0t",
                        e.name, got, want, $time);
            end
            got  = {QH1, QL1, pm1, cd1};
            want = disp((e.h0 + 12) % 24, e.m24, e.c1);
            checks++;
            if (got !== want) begin
               failures++;
               $display("FAIL %s dut1 got=%h want=%h t=%0t",
                        e.name, got, want, $time);
            end
         end
      end
   end

   task automatic push(longint dly, int h0, bit c0, bit c1, bit m24,
                       string name);
      exp_t e;
      e.due  = $time + dly;
      e.h0   = h0;
      e.c0   = c0;
      e.c1   = c1;
      e.m24  = m24;
      e.name = name;
      q.push_back(e);
   endtask

   // One clock: drive at negedge, expect state after next posedge.
   task automatic step(bit tk, bit es, bit em, bit up, bit dn, bit clr,
                       bit m24, int h0, bit c0, bit c1, string name);
      @(negedge CLK);
      en1hz  = tk;
      ENsec  = es;
      ENmin  = em;
      adj_up = up;
      adj_dn = dn;
      CLR    = clr;
      mode24 = m24;
      push(7, h0, c0, c1, m24, name);
   endtask

   initial begin : driver
      RST = 1'b1; CLR = 1'b0; en1hz = 1'b0; ENsec = 1'b0;
      ENmin = 1'b0; mode24 = 1'b1; adj_up = 1'b0; adj_dn = 1'b0;

      @(negedge CLK);
      push(2, 0, 0, 0, 1, "reset24");
      @(negedge CLK);
      mode24 = 1'b0;
      push(2, 0, 0, 0, 0, "reset12");
      @(negedge CLK);
      RST = 1'b0;
      mode24 = 1'b1;
      push(7, 0, 0, 0, 1, "release");

      for (int i = 1; i <= 24; i++)
         step(1, 1, 1, 0, 0, 0, 1, i % 24, i == 24, i == 12, "sweep");
      step(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, "carry_drop");

      step(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "no_enmin");
      step(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "no_enmin");
      step(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, "no_ensec");
      step(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, "no_tick");

      for (int i = 1; i <= 13; i++)
         step(1, 1, 1, 0, 0, 0, 1, i, 0, i == 12, "to13");
      step(0, 0, 0, 0, 0, 0, 0, 13, 0, 0, "h13_12h");
      step(0, 0, 0, 0, 0, 0, 1, 13, 0, 0, "h13_24h");
      step(0, 0, 0, 0, 0, 0, 0, 13, 0, 0, "toggle12");
      step(0, 0, 0, 0, 0, 0, 1, 13, 0, 0, "toggle24");

      step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, "clr");
      step(0, 0, 0, 0, 1, 0, 1, 23, 0, 0, "adj_dn_wrap");
      step(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, "adj_up_wrap");
      step(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, "adj_up");
      for (int i = 2; i <= 5; i++)
         step(0, 0, 0, 1, 0, 0, 1, i, 0, 0, "adj_to5");
      step(1, 1, 1, 1, 0, 0, 1, 6, 0, 0, "adj_tick");
      step(0, 0, 0, 1, 1, 0, 1, 6, 0, 0, "up_dn_hold");
      step(1, 1, 1, 1, 1, 0, 1, 6, 0, 0, "up_dn_tick");
      step(0, 0, 0, 0, 0, 0, 0, 6, 0, 0, "h6_12h");

      for (int i = 5; i >= 0; i--)
         step(0, 0, 0, 0, 1, 0, 1, i, 0, 0, "adj_dn");
      step(0, 0, 0, 0, 1, 0, 1, 23, 0, 0, "adj_dn_23");
      step(1, 1, 1, 1, 0, 0, 1, 0, 0, 0, "adj_wrap_tick");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "h0_12h");

      for (int i = 1; i <= 8; i++)
         step(0, 0, 0, 1, 0, 0, 1, i, 0, 0, "adj_to8");
      step(1, 1, 1, 0, 0, 1, 1, 0, 0, 0, "clr_tick");
      step(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, "clr_adj");

      for (int i = 1; i <= 3; i++)
         step(1, 1, 1, 0, 0, 0, 1, i, 0, 0, "to3");
      @(negedge CLK);
      en1hz = 1'b1;
      adj_up = 1'b1;
      RST = 1'b1;
      push(2, 0, 0, 0, 1, "async_rst");
      @(negedge CLK);
      RST = 1'b0;
      en1hz = 1'b0;
      adj_up = 1'b0;
      push(7, 0, 0, 0, 1, "post_rst");

      #30;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
